// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-capped arbiter sharing the status-flag FIFO write port between NREQ producers.
// Writes are gated combinationally by fifo_full so the FIFO can never overflow through this block.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int BURST_MAX = 4,
   localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_last,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 fifo_wr,
   output logic [DW-1:0]        fifo_data,
   input  logic                 fifo_full,
   input  logic                 fifo_threshold,
   output logic                 grant_valid,
   output logic [IDW-1:0]       grant_id
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Returns {found, index} of the first set mask bit searching upward from start, wrapping.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IDW-1:0]  start);
      logic [IDW:0] res;
      int           j;
      res = {(IDW+1){1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(start) + k) % NREQ;
         if (!res[IDW] && mask[j]) begin
            res = {1'b1, IDW'(j)};
         end
      end
      return res;
   endfunction

   state_t          state_r;
   logic [IDW-1:0]  owner_r;
   logic [IDW-1:0]  rr_ptr_r;
   logic [3:0]      beat_cnt_r;

   logic            granted_s;
   logic            accept_s;
   logic [4:0]      cnt_inc_s;
   logic [4:0]      limit_s;
   logic            rel_a_s;
   logic            rel_b_s;
   logic            rel_c_s;
   logic            release_s;
   logic [IDW-1:0]  next_ptr_s;
   logic [NREQ-1:0] excl_s;
   logic [IDW:0]    rel_pick_s;
   logic [IDW:0]    idle_pick_s;

   // Handshake, release conditions and next-owner search for the current cycle.
   always_comb begin
      granted_s  = (state_r == GRANT);
      accept_s   = 1'b0;
      if (granted_s) begin
         accept_s = req_valid[owner_r] & ~fifo_full;
      end else begin
         accept_s = 1'b0;
      end
      cnt_inc_s  = {1'b0, beat_cnt_r} + 5'd1;
      limit_s    = fifo_threshold ? 5'd1 : 5'(BURST_MAX);
      rel_a_s    = accept_s & req_last[owner_r];
      rel_b_s    = accept_s & (cnt_inc_s >= limit_s);
      rel_c_s    = granted_s & ~req_valid[owner_r];
      release_s  = granted_s & (rel_a_s | rel_b_s | rel_c_s);
      if (owner_r == IDW'(NREQ - 1)) begin
         next_ptr_s = {IDW{1'b0}};
      end else begin
         next_ptr_s = owner_r + {{(IDW-1){1'b0}}, 1'b1};
      end
      // A cap-only release keeps the owner eligible; it just loses priority.
      if (rel_a_s | rel_c_s) begin
         excl_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
      end else begin
         excl_s = {NREQ{1'b0}};
      end
      rel_pick_s  = rr_pick(req_valid & ~excl_s, next_ptr_s);
      idle_pick_s = rr_pick(req_valid, rr_ptr_r);
   end

   // Write-port outputs follow the accept decision within the same cycle.
   always_comb begin
      req_ready   = {NREQ{1'b0}};
      fifo_wr     = accept_s;
      fifo_data   = req_data[int'(owner_r)*DW +: DW];
      grant_valid = granted_s;
      grant_id    = owner_r;
      if (accept_s) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   // Arbitration FSM: grant, burst counting and same-cycle rotation on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         owner_r    <= {IDW{1'b0}};
         rr_ptr_r   <= {IDW{1'b0}};
         beat_cnt_r <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (idle_pick_s[IDW]) begin
                  owner_r    <= idle_pick_s[IDW-1:0];
                  beat_cnt_r <= 4'd0;
                  state_r    <= GRANT;
               end else begin
                  state_r    <= IDLE;
               end
            end
            GRANT: begin
               if (release_s) begin
                  rr_ptr_r <= next_ptr_s;
                  if (rel_pick_s[IDW]) begin
                     owner_r    <= rel_pick_s[IDW-1:0];
                     beat_cnt_r <= 4'd0;
                     state_r    <= GRANT;
                  end else begin
                     state_r    <= IDLE;
                  end
               end else if (accept_s) begin
                  beat_cnt_r <= cnt_inc_s[3:0];
               end else begin
                  beat_cnt_r <= beat_cnt_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               owner_r    <= {IDW{1'b0}};
               rr_ptr_r   <= {IDW{1'b0}};
               beat_cnt_r <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers with burst queues, a 16-entry FIFO occupancy
// model, a cycle-level reference arbiter feeding a scoreboard, and a separate monitor.
module tb_fifo_wr_arbiter;
   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int BURST_MAX = 4;
   localparam int IDW       = 2;
   localparam int DEPTH     = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_last;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                fifo_wr;
   logic [DW-1:0]       fifo_data;
   logic                fifo_full;
   logic                fifo_threshold;
   logic                grant_valid;
   logic [IDW-1:0]      grant_id;

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
      .fifo_full(fifo_full), .fifo_threshold(fifo_threshold),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
   } exp_t;

   int              checks = 0;
   int              errors = 0;
   beat_t           pq[NREQ][$];
   exp_t            exp_q[$];
   int              fcount = 0;
   bit              overflow = 1'b0;
   bit              pop_s = 1'b0;
   bit              wr_seen = 1'b0;
   logic [NREQ-1:0] acc_seen = '0;
   int              valid_pct, pop_pct, max_len;

   // Reference arbiter state (abstract: integers, not the RTL encoding)
   bit              m_grant = 1'b0;
   int              m_owner = 0;
   int              m_rr = 0;
   int              m_cnt = 0;
   bit              m_gv_now = 1'b0;
   int              m_gid_now = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find(input logic [NREQ-1:0] v, input int from, input int skip);
      int j;
      for (int k = 0; k < NREQ; k++) begin
         j = (from + k) % NREQ;
         if (v[j] && j != skip) return j;
      end
      return -1;
   endfunction

   // Predict this cycle's write and the state after the coming edge.
   task automatic model_step();
      int  w;
      bit  acc, ra, rb, rc;
      int  limit;
      m_gv_now  = m_grant;
      m_gid_now = m_owner;
      if (!rst_n) begin
         m_grant = 1'b0; m_owner = 0; m_rr = 0; m_cnt = 0;
         m_gv_now = 1'b0; m_gid_now = 0;
         return;
      end
      if (!m_grant) begin
         w = find(req_valid, m_rr, -1);
         if (w >= 0) begin
            m_owner = w; m_cnt = 0; m_grant = 1'b1;
         end
         return;
      end
      acc = req_valid[m_owner] && !fifo_full;
      if (acc) exp_q.push_back('{id: IDW'(m_owner), data: req_data[m_owner*DW +: DW]});
      limit = fifo_threshold ? 1 : BURST_MAX;
      ra = acc && req_last[m_owner];
      rb = acc && (m_cnt + 1 >= limit);
      rc = !req_valid[m_owner];
      if (ra || rb || rc) begin
         m_rr = (m_owner + 1) % NREQ;
         w = find(req_valid, m_rr, (ra || rc) ? m_owner : -1);
         if (w >= 0) begin
            m_owner = w; m_cnt = 0;
         end else begin
            m_grant = 1'b0;
         end
      end else if (acc) begin
         m_cnt = m_cnt + 1;
      end
   endtask

   always @(negedge clk) begin
      #1;
      model_step();
   end

   // Monitor: compares DUT outputs against the scoreboard and invariants.
   always @(negedge clk) begin
      exp_t e;
      int   rid, pc;
      #2;
      rid = -1; pc = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin rid = i; pc++; end
      check("grant_valid", 32'(grant_valid), 32'(m_gv_now));
      check("grant_id", 32'(grant_id), 32'(m_gid_now));
      check("ready_popcount", 32'(pc), 32'(fifo_wr));
      if (fifo_wr) check("wr_while_full", 32'(fifo_full), 32'd0);
      if (!rst_n) check("reset_outputs", {30'd0, fifo_wr, grant_valid} | 32'(req_ready), 32'd0);
      if (fifo_wr) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("write_id", 32'(rid), 32'(e.id));
            check("write_data", 32'(fifo_data), 32'(e.data));
         end
      end
      if (exp_q.size() != 0) begin
         check("missed_write", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      acc_seen = req_ready;
      wr_seen  = fifo_wr;
   end

   // FIFO occupancy model updated at the write edge.
   always @(posedge clk) begin
      if (wr_seen && fcount >= DEPTH) overflow <= 1'b1;
      fcount <= fcount + (wr_seen ? 1 : 0) - (pop_s ? 1 : 0);
   end

   task automatic drive_cycle(input bit rst_val);
      beat_t b;
      int    len;
      @(negedge clk);
      rst_n = rst_val;
      for (int i = 0; i < NREQ; i++) if (acc_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() == 0 && $urandom_range(99) < 60) begin
            len = $urandom_range(max_len, 1);
            for (int k = 0; k < len; k++) begin
               b.data = 8'($urandom_range(255));
               b.last = (k == len - 1);
               pq[i].push_back(b);
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() > 0) begin
            req_valid[i]          = ($urandom_range(99) < valid_pct);
            req_last[i]           = pq[i][0].last;
            req_data[i*DW +: DW]  = pq[i][0].data;
         end else begin
            req_valid[i]          = 1'b0;
            req_last[i]           = 1'b0;
            req_data[i*DW +: DW]  = 8'd0;
         end
      end
      pop_s          = (fcount > 0) && ($urandom_range(99) < pop_pct);
      fifo_full      = (fcount >= DEPTH);
      fifo_threshold = (fcount >= 8);
   endtask

   task automatic run_phase(input int n, input int vp, input int pp, input int ml);
      valid_pct = vp; pop_pct = pp; max_len = ml;
      for (int c = 0; c < n; c++) drive_cycle(1'b1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
      fifo_full = 1'b0; fifo_threshold = 1'b0;
      valid_pct = 100; pop_pct = 100; max_len = 1;
      for (int c = 0; c < 3; c++) drive_cycle(1'b0);
      run_phase(200, 100, 100, 1);
      run_phase(400, 100, 100, 10);
      valid_pct = 100;
      for (int c = 0; c < 3; c++) drive_cycle(1'b0);
      run_phase(600, 100, 30, 10);
      run_phase(600, 70, 60, 6);
      run_phase(400, 90, 45, 12);
      run_phase(300, 100, 20, 15);
      run_phase(100, 0, 100, 1);
      @(negedge clk);
      #3;
      check("fifo_overflow", 32'(overflow), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
